// File: rtl/freq_pkg.sv
// freq_pkg: shared constants and FSM encodings for the tone generator / meter path.
package freq_pkg;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_FW     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/seq_udiv.sv
// seq_udiv: W-bit restoring divider, one quotient bit per clock.
// The first step is taken on the start cycle itself, so done pulses W cycles after start.
// The divisor is one bit wider than the dividend so callers can pass 2*f without overflow.
module seq_udiv
    import freq_pkg::*;
#(
    parameter int unsigned W = DEF_FW
) (
    input  logic         in_clk_50M,
    input  logic         in_clr,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W:0]   divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W:0]    rem_q;
    logic [W:0]    dvs_q;
    logic [W-1:0]  quo_q;
    logic [CW-1:0] left_q;

    logic [W:0]    rem_src;
    logic [W:0]    dvs_src;
    logic [W-1:0]  quo_src;
    logic [W+1:0]  shifted;
    logic          fits;
    logic [W:0]    rem_nxt;
    logic [W-1:0]  quo_nxt;

    // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
    always_comb begin
        rem_src = start ? '0 : rem_q;
        quo_src = start ? dividend : quo_q;
        dvs_src = start ? divisor : dvs_q;
        shifted = {rem_src, quo_src[W-1]};
        fits    = (shifted >= {1'b0, dvs_src});
        rem_nxt = fits ? (W+1)'(shifted - {1'b0, dvs_src}) : shifted[W:0];
        quo_nxt = {quo_src[W-2:0], fits};
    end

    // Iteration registers; left_q counts remaining steps down to zero.
    always_ff @(posedge in_clk_50M) begin
        if (in_clr) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            left_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q  <= rem_nxt;
                quo_q  <= quo_nxt;
                dvs_q  <= divisor;
                left_q <= CW'(W - 1);
            end else if (left_q != '0) begin
                rem_q  <= rem_nxt;
                quo_q  <= quo_nxt;
                left_q <= left_q - CW'(1);
                done   <= (left_q == CW'(1));
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/freq_sig_gen.sv
// freq_sig_gen: programmable 50%-duty square-wave source (Hz request -> half-period count).
// Optional burst mode is compiled in with FREQ_GEN_BURST_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | accepting requests; current setting (if any) keeps running
//   ST_DIV  | divider computing CLK_HZ / (2*f)
//   ST_PEND | new half-period ready, waiting for a glitch-free apply point
module freq_sig_gen
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned FW     = DEF_FW
) (
    input  logic          in_clk_50M,
    input  logic          in_clr,
    input  logic [FW-1:0] in_freq_hz,
    input  logic          in_load,
`ifdef FREQ_GEN_BURST_EN
    input  logic [15:0]   in_burst_n,
    output logic          burst_done,
`endif
    output logic          busy,
    output logic          err,
    output logic          sig_out,
    output logic [FW-1:0] cur_freq_hz
);

    state_t        state_q;
    state_t        state_d;

    logic [FW-1:0] f_q;
    logic [FW-1:0] new_half_q;
    logic [FW-1:0] half_q;
    logic [FW-1:0] cnt_q;

    logic          div_start;
    logic          div_done;
    logic [FW-1:0] div_q;

    logic          load_ok;
    logic          tone_wrap;
    logic          apply;
    logic          keep_toggling;

`ifdef FREQ_GEN_BURST_EN
    logic [15:0]   burst_n_q;
    logic [15:0]   bcnt_q;
    logic          bon_q;
`endif

    seq_udiv #(.W(FW)) u_div (
        .in_clk_50M (in_clk_50M),
        .in_clr     (in_clr),
        .start      (div_start),
        .dividend   (FW'(CLK_HZ)),
        .divisor    ({in_freq_hz, 1'b0}),
        .done       (div_done),
        .quotient   (div_q)
    );

    // State register.
    always_ff @(posedge in_clk_50M) begin
        if (in_clr) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a zero request skips the divider and goes straight to the apply wait.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_ok)  state_d = (in_freq_hz != '0) ? ST_DIV : ST_PEND;
            ST_DIV:  if (div_done) state_d = (div_q == '0) ? ST_IDLE : ST_PEND;
            ST_PEND: if (apply)    state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and apply-point decode.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        load_ok       = in_load && (state_q == ST_IDLE);
        div_start     = load_ok && (in_freq_hz != '0);
        err           = (state_q == ST_DIV) && div_done && (div_q == '0);
        tone_wrap     = (half_q != '0) && (cnt_q == half_q - FW'(1));
        apply         = (state_q == ST_PEND) && ((half_q == '0) || tone_wrap);
        // Running-to-running switch: the apply edge is an ordinary toggle, so phase is preserved.
        keep_toggling = apply && (new_half_q != '0) && (half_q != '0);
    end

    // Pending request: frequency latched at load, half-period captured when the divider finishes.
    always_ff @(posedge in_clk_50M) begin
        if (in_clr) begin
            f_q        <= '0;
            new_half_q <= '0;
`ifdef FREQ_GEN_BURST_EN
            burst_n_q  <= '0;
`endif
        end else if (load_ok) begin
            f_q        <= in_freq_hz;
            new_half_q <= '0;
`ifdef FREQ_GEN_BURST_EN
            burst_n_q  <= in_burst_n;
`endif
        end else if ((state_q == ST_DIV) && div_done) begin
            new_half_q <= div_q;
        end
    end

    // Tone counter and output register; new settings land only on apply.
    always_ff @(posedge in_clk_50M) begin
        if (in_clr) begin
            half_q      <= '0;
            cnt_q       <= '0;
            sig_out     <= 1'b0;
            cur_freq_hz <= '0;
`ifdef FREQ_GEN_BURST_EN
            bcnt_q      <= '0;
            bon_q       <= 1'b0;
            burst_done  <= 1'b0;
`endif
        end else begin
`ifdef FREQ_GEN_BURST_EN
            burst_done <= 1'b0;
`endif
            if (apply) begin
                half_q      <= new_half_q;
                cur_freq_hz <= f_q;
                cnt_q       <= '0;
                sig_out     <= keep_toggling ? ~sig_out : 1'b0;
`ifdef FREQ_GEN_BURST_EN
                bon_q       <= (new_half_q != '0) && (burst_n_q != '0);
                // A rising apply toggle already counts as the first burst edge.
                bcnt_q      <= burst_n_q - ((keep_toggling && !sig_out) ? 16'd1 : 16'd0);
`endif
            end else if (tone_wrap) begin
                cnt_q <= '0;
`ifdef FREQ_GEN_BURST_EN
                if (bon_q && sig_out && (bcnt_q == '0)) begin
                    sig_out     <= 1'b0;
                    half_q      <= '0;
                    cur_freq_hz <= '0;
                    bon_q       <= 1'b0;
                    burst_done  <= 1'b1;
                end else begin
                    sig_out <= ~sig_out;
                    if (bon_q && !sig_out) bcnt_q <= bcnt_q - 16'd1;
                end
`else
                sig_out <= ~sig_out;
`endif
            end else if (half_q != '0) begin
                cnt_q <= cnt_q + FW'(1);
            end
        end
    end

endmodule
